// File: rtl/corner_ctrl_pkg.sv
// Shared corner-set types, field layout, FSM encoding and the full-frame default set.
package corner_ctrl_pkg;

  localparam int CX_W        = 10;
  localparam int CY_W        = 10;
  localparam int CORNER_W    = CX_W + CY_W;
  localparam int NUM_CORNERS = 4;
  localparam int SET_W       = CORNER_W * NUM_CORNERS;
  localparam int CY_LSB      = 0;
  localparam int CX_LSB      = CY_W;

  typedef logic [CX_W-1:0] cx_t;
  typedef logic [CY_W-1:0] cy_t;

  // x sits in the upper half of each 20-bit corner slice.
  typedef struct packed {
    cx_t x;
    cy_t y;
  } corner_t;

  typedef corner_t [NUM_CORNERS-1:0] corner_set_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  function automatic int corner_lsb(input int idx);
    return idx * CORNER_W;
  endfunction

  function automatic corner_set_t full_frame(input cx_t x_max, input cy_t y_max);
    corner_set_t s;
    s[0].x = '0;    s[0].y = '0;
    s[1].x = x_max; s[1].y = '0;
    s[2].x = x_max; s[2].y = y_max;
    s[3].x = '0;    s[3].y = y_max;
    return s;
  endfunction

  localparam corner_set_t FULL_FRAME_DEFAULT = full_frame(cx_t'(639), cy_t'(479));

endpackage

// File: rtl/corner_ctrl_if.sv
// Detector, manual-control, frame-sync and committed-output bundle of corner_ctrl.
interface corner_ctrl_if;
  import corner_ctrl_pkg::*;

  corner_set_t det_corners;
  logic        det_valid;
  logic        det_ready;
  logic [1:0]  man_idx;
  logic        man_up;
  logic        man_down;
  logic        man_left;
  logic        man_right;
  logic        mode_auto;
  logic        frame_start;
  logic        xform_busy;
  corner_set_t corners_A;
  corner_set_t corners_B;
  logic        corners_sel;
  logic        update;
  logic        pending;

  modport master (
    output det_corners, det_valid, man_idx, man_up, man_down, man_left, man_right,
           mode_auto, frame_start, xform_busy,
    input  det_ready, corners_A, corners_B, corners_sel, update, pending
  );

  modport slave (
    input  det_corners, det_valid, man_idx, man_up, man_down, man_left, man_right,
           mode_auto, frame_start, xform_busy,
    output det_ready, corners_A, corners_B, corners_sel, update, pending
  );

endinterface

// File: rtl/corner_nudge.sv
// Combinational saturating nudge of one corner; opposing pulses on an axis cancel.
module corner_nudge
  import corner_ctrl_pkg::*;
#(
  parameter int X_MAX = 639,
  parameter int Y_MAX = 479,
  parameter int STEP  = 1
) (
  input  corner_t corner_in,
  input  logic    en,
  input  logic    up,
  input  logic    down,
  input  logic    left,
  input  logic    right,
  output corner_t corner_out
);

  localparam cx_t X_LIM  = cx_t'(X_MAX);
  localparam cy_t Y_LIM  = cy_t'(Y_MAX);
  localparam cx_t STEP_X = cx_t'(STEP);
  localparam cy_t STEP_Y = cy_t'(STEP);

  logic x_hi_sat, x_lo_sat, y_hi_sat, y_lo_sat;

  // Compared in int so the sum never wraps inside the 10-bit field.
  assign x_hi_sat = (int'(corner_in.x) + STEP) > X_MAX;
  assign x_lo_sat = int'(corner_in.x) < STEP;
  assign y_hi_sat = (int'(corner_in.y) + STEP) > Y_MAX;
  assign y_lo_sat = int'(corner_in.y) < STEP;

  always_comb begin
    corner_out = corner_in;
    if (en) begin
      if (right && !left)
        corner_out.x = x_hi_sat ? X_LIM : corner_in.x + STEP_X;
      else if (left && !right)
        corner_out.x = x_lo_sat ? '0 : corner_in.x - STEP_X;

      if (down && !up)
        corner_out.y = y_hi_sat ? Y_LIM : corner_in.y + STEP_Y;
      else if (up && !down)
        corner_out.y = y_lo_sat ? '0 : corner_in.y - STEP_Y;
    end
  end

endmodule

// File: rtl/corner_ctrl.sv
// Shadow/commit controller for the corner mux; commits land 2 cycles after a frame_start seen with xform_busy low.
// det_ready drops only during the commit cycle; manual nudges are never back-pressured.
module corner_ctrl
  import corner_ctrl_pkg::*;
#(
  parameter int X_MAX = 639,
  parameter int Y_MAX = 479,
  parameter int STEP  = 1
) (
  input logic         clk,
  input logic         reset,
  corner_ctrl_if.slave bus
);

  localparam corner_set_t FULL = full_frame(cx_t'(X_MAX), cy_t'(Y_MAX));

  state_t      state;
  corner_set_t sh_A, sh_B, sh_B_nxt;
  corner_set_t com_A, com_B;
  logic        sh_sel, com_sel;
  logic        upd_q, pend_q;
  logic        handshake, nudge_hit;

  assign bus.det_ready   = !reset && (state != ST_COMMIT);
  assign bus.corners_A   = com_A;
  assign bus.corners_B   = com_B;
  assign bus.corners_sel = com_sel;
  assign bus.update      = upd_q;
  assign bus.pending     = pend_q;

  assign handshake = bus.det_valid && bus.det_ready;
  // A nudge counts as applied whenever an axis has a net direction, even if it saturates.
  assign nudge_hit = (bus.man_up ^ bus.man_down) | (bus.man_left ^ bus.man_right);

  for (genvar i = 0; i < NUM_CORNERS; i++) begin : g_nudge
    corner_nudge #(
      .X_MAX (X_MAX),
      .Y_MAX (Y_MAX),
      .STEP  (STEP)
    ) u_nudge (
      .corner_in  (sh_B[i]),
      .en         (bus.man_idx == 2'(i)),
      .up         (bus.man_up),
      .down       (bus.man_down),
      .left       (bus.man_left),
      .right      (bus.man_right),
      .corner_out (sh_B_nxt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      upd_q   <= 1'b0;
      pend_q  <= 1'b0;
      sh_A    <= FULL;
      sh_B    <= FULL;
      sh_sel  <= 1'b0;
      com_A   <= FULL;
      com_B   <= FULL;
      com_sel <= 1'b0;
    end else begin
      upd_q  <= 1'b0;
      sh_sel <= bus.mode_auto;
      sh_B   <= sh_B_nxt;
      if (handshake)
        sh_A <= bus.det_corners;

      unique case (state)
        ST_IDLE: begin
          if (handshake || nudge_hit || (sh_sel != com_sel)) begin
            state  <= ST_PEND;
            pend_q <= 1'b1;
          end
        end
        ST_PEND: begin
          if (bus.frame_start && !bus.xform_busy)
            state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          // Committed copy takes the pre-edge shadows; a nudge landing now re-arms PEND.
          com_A   <= sh_A;
          com_B   <= sh_B;
          com_sel <= sh_sel;
          upd_q   <= 1'b1;
          state   <= nudge_hit ? ST_PEND : ST_IDLE;
          pend_q  <= nudge_hit;
        end
        default: begin
          state  <= ST_IDLE;
          pend_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_corner_ctrl.sv
// Directed scenarios plus randomized traffic against a cycle-level reference of the shadow/commit rules.
module tb_corner_ctrl;

  localparam int X_MAX = 639;
  localparam int Y_MAX = 479;
  localparam int STEP  = 1;
  localparam logic [79:0] FULL = {10'd0, 10'd479, 10'd639, 10'd479, 10'd639, 10'd0, 20'd0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  corner_ctrl_if bus();

  corner_ctrl #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .STEP(STEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: shadow and committed copies plus "change waiting" / "commit due" flags.
  logic [79:0] m_sha, m_ca, m_cb;
  int          m_sbx[4], m_sby[4];
  logic        m_shsel, m_csel, m_wait, m_due, m_upd;

  function automatic logic [79:0] pack_sb();
    logic [79:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      v[20*i+10 +: 10] = 10'(m_sbx[i]);
      v[20*i    +: 10] = 10'(m_sby[i]);
    end
    return v;
  endfunction

  function automatic int clamp(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    m_sha = FULL; m_ca = FULL; m_cb = FULL;
    m_sbx[0] = 0; m_sbx[1] = X_MAX; m_sbx[2] = X_MAX; m_sbx[3] = 0;
    m_sby[0] = 0; m_sby[1] = 0;     m_sby[2] = Y_MAX; m_sby[3] = Y_MAX;
    m_shsel = 1'b0; m_csel = 1'b0; m_wait = 1'b0; m_due = 1'b0; m_upd = 1'b0;
  endtask

  task automatic model_edge();
    logic hs, nudge;
    int   dx, dy, k;
    if (reset) begin
      model_reset();
      return;
    end
    hs    = bus.det_valid && !m_due;
    dx    = (bus.man_right ? STEP : 0) - (bus.man_left ? STEP : 0);
    dy    = (bus.man_down  ? STEP : 0) - (bus.man_up   ? STEP : 0);
    nudge = (dx != 0) || (dy != 0);
    m_upd = 1'b0;
    if (m_due) begin
      m_ca = m_sha; m_cb = pack_sb(); m_csel = m_shsel;
      m_upd = 1'b1; m_due = 1'b0; m_wait = nudge;
    end else if (m_wait) begin
      if (bus.frame_start && !bus.xform_busy) begin
        m_wait = 1'b0; m_due = 1'b1;
      end
    end else if (hs || nudge || (m_shsel != m_csel)) begin
      m_wait = 1'b1;
    end
    m_shsel = bus.mode_auto;
    if (hs) m_sha = bus.det_corners;
    k = int'(bus.man_idx);
    m_sbx[k] = clamp(m_sbx[k] + dx, X_MAX);
    m_sby[k] = clamp(m_sby[k] + dy, Y_MAX);
  endtask

  task automatic compare_outputs();
    check("corners_A",   bus.corners_A,   m_ca);
    check("corners_B",   bus.corners_B,   m_cb);
    check("corners_sel", 80'(bus.corners_sel), 80'(m_csel));
    check("update",      80'(bus.update),      80'(m_upd));
    check("pending",     80'(bus.pending),     80'(m_wait || m_due));
    check("det_ready",   80'(bus.det_ready),   80'(!reset && !m_due));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic quiet();
    bus.det_valid = 1'b0; bus.man_up = 1'b0; bus.man_down = 1'b0;
    bus.man_left = 1'b0; bus.man_right = 1'b0; bus.frame_start = 1'b0;
    bus.xform_busy = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    quiet();
    bus.mode_auto = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic commit_now();
    bus.frame_start = 1'b1; bus.xform_busy = 1'b0;
    tick();
    bus.frame_start = 1'b0;
    tick();
  endtask

  logic [79:0] d;
  logic [95:0] r;
  int          n_upd;

  initial begin
    bus.det_corners = '0;
    bus.man_idx = 2'd0;
    bus.mode_auto = 1'b0;
    quiet();

    // Reset then idle: full-frame manual set, manual select, no update.
    do_reset();
    n_upd = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.update) n_upd++;
    end
    check("idle_B_full", bus.corners_B, FULL);
    check("idle_sel", 80'(bus.corners_sel), 80'(0));
    check("idle_no_update", 80'(n_upd), 80'(0));

    // Detector load of corner 2, then auto mode commit.
    d = FULL;
    d[59:40] = {10'd300, 10'd200};
    bus.det_corners = d; bus.det_valid = 1'b1; bus.mode_auto = 1'b1;
    tick();
    bus.det_valid = 1'b0;
    tick();
    commit_now();
    check("auto_slot2", 80'(bus.corners_A[2]), 80'({10'd300, 10'd200}));
    check("auto_sel", 80'(bus.corners_sel), 80'(1));
    check("auto_update", 80'(bus.update), 80'(1));
    tick();
    check("auto_update_once", 80'(bus.update), 80'(0));

    // Right on a corner already at X_MAX saturates; downs move y.
    bus.man_idx = 2'd1;
    for (int i = 0; i < 5; i++) begin
      bus.man_right = 1'b1; tick(); bus.man_right = 1'b0; tick();
    end
    for (int i = 0; i < 3; i++) begin
      bus.man_down = 1'b1; tick(); bus.man_down = 1'b0; tick();
    end
    commit_now();
    check("sat_corner1", 80'(bus.corners_B[1]), 80'({10'd639, 10'd3}));

    // frame_start while busy is ignored; the next clean one commits.
    tick();
    bus.man_idx = 2'd0; bus.man_right = 1'b1;
    tick();
    bus.man_right = 1'b0;
    bus.frame_start = 1'b1; bus.xform_busy = 1'b1;
    tick();
    quiet();
    tick(); tick();
    check("busy_pending", 80'(bus.pending), 80'(1));
    check("busy_no_update", 80'(bus.update), 80'(0));
    commit_now();
    check("busy_then_commit", 80'(bus.update), 80'(1));

    // Opposing up+down cancel while left still applies: (5,5) -> (4,5).
    do_reset();
    bus.man_idx = 2'd0;
    for (int i = 0; i < 5; i++) begin
      bus.man_right = 1'b1; bus.man_down = 1'b1; tick();
      quiet(); tick();
    end
    bus.man_up = 1'b1; bus.man_down = 1'b1; bus.man_left = 1'b1;
    tick();
    quiet();
    tick();
    commit_now();
    check("cancel_corner0", 80'(bus.corners_B[0]), 80'({10'd4, 10'd5}));

    // Reset in PEND discards the loaded shadow.
    do_reset();
    d = FULL;
    d[19:0] = {10'd123, 10'd45};
    bus.det_corners = d; bus.det_valid = 1'b1;
    tick();
    bus.det_valid = 1'b0;
    tick();
    check("pend_before_reset", 80'(bus.pending), 80'(1));
    do_reset();
    check("rst_A_full", bus.corners_A, FULL);
    check("rst_pending", 80'(bus.pending), 80'(0));
    n_upd = 0;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.update) n_upd++;
    end
    check("rst_no_update", 80'(n_upd), 80'(0));
    check("rst_A_still_full", bus.corners_A, FULL);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r = {$urandom(), $urandom(), $urandom()};
      bus.det_corners = r[79:0];
      bus.det_valid   = ($urandom_range(0, 4) == 0);
      bus.man_idx     = 2'($urandom_range(0, 3));
      bus.man_up      = ($urandom_range(0, 5) == 0);
      bus.man_down    = ($urandom_range(0, 5) == 0);
      bus.man_left    = ($urandom_range(0, 5) == 0);
      bus.man_right   = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) bus.mode_auto = ~bus.mode_auto;
      bus.frame_start = ($urandom_range(0, 5) == 0);
      bus.xform_busy  = ($urandom_range(0, 2) == 0);
      reset           = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0;
    quiet();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
